// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit framer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even parity is the XOR of the payload, odd is its inverse.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_o
);

    assign par_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start, LSB-first data, optional parity, one or two stop bits,
// each held for a latched number of clocks; every output comes straight from a flop.
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESC_W-1:0]    PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    tx_state_e             state_q, state_d;
    logic [PRESC_W-1:0]    presc_cnt_q, presc_cnt_d;
    logic [PRESC_W-1:0]    presc_last_q, presc_last_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  par_calc;
    logic                  bit_end;
    logic                  accept;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .par_o     (par_calc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            presc_cnt_q  <= '0;
            presc_last_q <= '0;
            bit_cnt_q    <= '0;
            stop_idx_q   <= 1'b0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            tx_q         <= LINE_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_cnt_q  <= presc_cnt_d;
            presc_last_q <= presc_last_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_idx_q   <= stop_idx_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        presc_cnt_d  = presc_cnt_q;
        presc_last_d = presc_last_q;
        bit_cnt_d    = bit_cnt_q;
        stop_idx_d   = stop_idx_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        accept       = 1'b0;
        bit_end      = (presc_cnt_q == presc_last_q);

        if (state_q != IDLE) begin
            presc_cnt_d = bit_end ? '0 : presc_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                accept = DATA_VALID;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // The DONE cycle doubles as an accept slot so frames can run back to back.
                    if (stop_idx_q == stop2_q) begin
                        accept  = DATA_VALID;
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d      = START;
            presc_cnt_d  = '0;
            bit_cnt_d    = '0;
            stop_idx_d   = 1'b0;
            data_d       = P_DATA;
            par_en_d     = PAR_EN;
            par_bit_d    = par_calc;
            stop2_d      = STOP2;
            presc_last_d = (PRESCALE == '0) ? '0 : PRESCALE - 1'b1;
        end

        // Outputs are derived from the next state so they land in flops with no extra lag.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_cnt_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (stop_idx_d == stop2_d) && (presc_cnt_d == presc_last_d);
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule
